// File: rtl/grid_renderer.sv
// Playfield renderer: turns the VGA timing counters into a cell-map lookup and drives rgb/Hsync/Vsync.
// The 30x30 map is written by the game logic and wiped by a clear sweep that runs during vertical blank.
module grid_renderer #(
    parameter int         H_START   = 224,
    parameter int         V_START   = 35,
    parameter int         GRID_N    = 30,
    parameter int         CELL_LOG2 = 4,
    parameter logic [7:0] BLACK     = 8'h00,
    parameter logic [7:0] BLUE      = 8'h03,
    parameter logic [7:0] RED       = 8'hE0,
    parameter logic [7:0] GREEN     = 8'h1C
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    input  logic [9:0] h_counter,
    input  logic [9:0] v_counter,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [4:0] wr_x,
    input  logic [4:0] wr_y,
    input  logic [1:0] wr_cell,
    output logic       wr_err,
    input  logic       clear_req,
    output logic       clear_busy,
    output logic [7:0] rgb,
    output logic       Hsync,
    output logic       Vsync
);

    localparam int         GRID_PIX  = GRID_N << CELL_LOG2;
    localparam int         DEPTH     = GRID_N * GRID_N;
    localparam logic [9:0] H_LO      = 10'(H_START);
    localparam logic [9:0] H_HI      = 10'(H_START + GRID_PIX);
    localparam logic [9:0] V_LO      = 10'(V_START);
    localparam logic [9:0] V_HI      = 10'(V_START + GRID_PIX);
    localparam logic [9:0] LAST_ADDR = 10'(DEPTH - 1);
    localparam logic [9:0] ROW_PITCH = 10'(GRID_N);
    localparam logic [4:0] GRID_N5   = 5'(GRID_N);

    typedef enum logic [1:0] {IDLE, PEND, SWEEP} state_t;

    function automatic logic [7:0] code_colour(input logic [1:0] code);
        case (code)
            2'd0:    return BLACK;
            2'd1:    return BLUE;
            2'd2:    return RED;
            default: return GREEN;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [9:0] sweep_addr_q, sweep_addr_d;
    logic       clear_busy_q, clear_busy_d;
    logic       wr_err_q, wr_err_d;
    logic       in_grid_q, in_grid_d;
    logic       hs0_q, hs0_d, vs0_q, vs0_d;
    logic [1:0] rd_code_q, rd_code_d;
    logic [7:0] rgb_q, rgb_d;
    logic       hsync_q, hsync_d, vsync_q, vsync_d;

    logic [1:0] mem [DEPTH];
    logic [9:0] h_cell, v_cell, rd_addr, wr_addr, mem_waddr;
    logic       in_grid_s0, wr_fire, wr_oob, mem_we;
    logic [1:0] mem_wdata;

    assign wr_ready   = ~clear_busy_q;
    assign wr_err     = wr_err_q;
    assign clear_busy = clear_busy_q;
    assign rgb        = rgb_q;
    assign Hsync      = hsync_q;
    assign Vsync      = vsync_q;

    // NOTE: every signal assigned here gets a default first, so no path leaves a latch behind.
    always_comb begin
        h_cell     = (h_counter - H_LO) >> CELL_LOG2;
        v_cell     = (v_counter - V_LO) >> CELL_LOG2;
        in_grid_s0 = (h_counter >= H_LO) && (h_counter < H_HI) &&
                     (v_counter >= V_LO) && (v_counter < V_HI);
        rd_addr    = in_grid_s0 ? (v_cell * ROW_PITCH + h_cell) : '0;

        wr_fire = wr_valid && wr_ready;
        wr_oob  = (wr_x >= GRID_N5) || (wr_y >= GRID_N5);
        wr_addr = 10'(wr_y) * ROW_PITCH + 10'(wr_x);

        // Sweep and producer writes never coincide: wr_ready is low for the whole sweep.
        mem_we    = (state_q == SWEEP) || (wr_fire && !wr_oob);
        mem_waddr = (state_q == SWEEP) ? sweep_addr_q : wr_addr;
        mem_wdata = (state_q == SWEEP) ? 2'd0 : wr_cell;

        state_d      = state_q;
        sweep_addr_d = sweep_addr_q;
        case (state_q)
            IDLE:    if (clear_req) state_d = PEND;
            PEND:    if (pix_en && v_counter == V_HI) begin
                         state_d      = SWEEP;
                         sweep_addr_d = '0;
                     end
            SWEEP:   if (sweep_addr_q == LAST_ADDR) state_d = IDLE;
                     else sweep_addr_d = sweep_addr_q + 10'd1;
            default: state_d = IDLE;
        endcase
        clear_busy_d = (state_d != IDLE);
        wr_err_d     = wr_fire && wr_oob;

        in_grid_d = in_grid_q;
        hs0_d     = hs0_q;
        vs0_d     = vs0_q;
        rd_code_d = rd_code_q;
        rgb_d     = rgb_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        if (pix_en) begin
            in_grid_d = in_grid_s0;
            hs0_d     = hsync_in;
            vs0_d     = vsync_in;
            rd_code_d = mem[rd_addr];
            rgb_d     = in_grid_q ? code_colour(rd_code_q) : BLACK;
            hsync_d   = hs0_q;
            vsync_d   = vs0_q;
        end
        if (clear_busy_q) rgb_d = BLACK;
    end

    // NOTE: the map has no reset; the clear sweep initialises it so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SWEEP;
            sweep_addr_q <= '0;
            clear_busy_q <= 1'b1;
            wr_err_q     <= 1'b0;
            in_grid_q    <= 1'b0;
            hs0_q        <= 1'b1;
            vs0_q        <= 1'b1;
            rd_code_q    <= 2'd0;
            rgb_q        <= BLACK;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            sweep_addr_q <= sweep_addr_d;
            clear_busy_q <= clear_busy_d;
            wr_err_q     <= wr_err_d;
            in_grid_q    <= in_grid_d;
            hs0_q        <= hs0_d;
            vs0_q        <= vs0_d;
            rd_code_q    <= rd_code_d;
            rgb_q        <= rgb_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
        end
    end

endmodule

// File: tb/tb_grid_renderer.sv
// Self-checking bench for grid_renderer: pixel vectors go through a scoreboard queue that
// models the two-tick render pipeline; writes and clears are checked with hand-written sequences.
`timescale 1ns/1ps
module tb_grid_renderer;

    localparam logic [7:0] BLACK = 8'h00;
    localparam logic [7:0] BLUE  = 8'h03;
    localparam logic [7:0] RED   = 8'hE0;
    localparam logic [7:0] GREEN = 8'h1C;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_en;
    logic [9:0] h_counter, v_counter;
    logic       hsync_in, vsync_in;
    logic       wr_valid, wr_ready;
    logic [4:0] wr_x, wr_y;
    logic [1:0] wr_cell;
    logic       wr_err, clear_req, clear_busy;
    logic [7:0] rgb;
    logic       Hsync, Vsync;

    grid_renderer dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .h_counter(h_counter), .v_counter(v_counter),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_cell(wr_cell), .wr_err(wr_err),
        .clear_req(clear_req), .clear_busy(clear_busy),
        .rgb(rgb), .Hsync(Hsync), .Vsync(Vsync)
    );

    always #5 clk = ~clk;

    typedef struct {int h; int v; logic [7:0] rgb; logic hs; logic vs; logic chk;} exp_t;
    typedef struct {int h; int v; logic hs; logic vs; logic [7:0] rgb;} vec_t;

    exp_t       sb_q[$];
    vec_t       vecs[13];
    logic [1:0] model [30][30];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] colour(input logic [1:0] code);
        case (code)
            2'd0:    return BLACK;
            2'd1:    return BLUE;
            2'd2:    return RED;
            default: return GREEN;
        endcase
    endfunction

    // One pix_en tick every 4 clks; the output after this tick belongs to the previous tick.
    task automatic tick(input int h, input int v, input logic hs, input logic vs,
                        input logic [7:0] exp_rgb, input logic chk);
        exp_t e, f;
        @(negedge clk);
        pix_en = 1'b1; h_counter = 10'(h); v_counter = 10'(v); hsync_in = hs; vsync_in = vs;
        @(negedge clk);
        pix_en = 1'b0;
        if (sb_q.size() > 0) begin
            f = sb_q.pop_front();
            if (f.chk)
                check($sformatf("pixel(h=%0d,v=%0d) {rgb,Hsync,Vsync}", f.h, f.v),
                      32'({rgb, Hsync, Vsync}), 32'({f.rgb, f.hs, f.vs}));
        end
        e.h = h; e.v = v; e.rgb = exp_rgb; e.hs = hs; e.vs = vs; e.chk = chk;
        sb_q.push_back(e);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic flush();
        tick(0, 0, 1'b1, 1'b1, BLACK, 1'b0);
    endtask

    task automatic scan();
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 30; c++)
                tick(224 + 16 * c + 1, 35 + 16 * r + 1, 1'b1, 1'b1, colour(model[c][r]), 1'b1);
        flush();
    endtask

    task automatic model_clear();
        for (int x = 0; x < 30; x++)
            for (int y = 0; y < 30; y++)
                model[x][y] = 2'd0;
    endtask

    task automatic write_cell(input int x, input int y, input int code, input logic exp_err);
        int n;
        @(negedge clk);
        wr_valid = 1'b1; wr_x = 5'(x); wr_y = 5'(y); wr_cell = 2'(code);
        n = 0;
        while (!wr_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("wr_ready for write (%0d,%0d)", x, y), 32'(wr_ready), 32'd1);
        @(negedge clk);
        wr_valid = 1'b0;
        check($sformatf("wr_err after write (%0d,%0d)", x, y), 32'(wr_err), 32'(exp_err));
        @(negedge clk);
        check($sformatf("wr_err one clk (%0d,%0d)", x, y), 32'(wr_err), 32'd0);
        if (!exp_err) model[x][y] = 2'(code);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (clear_busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rgb"},        32'(rgb),        32'(BLACK));
        check({tag, " Hsync"},      32'(Hsync),      32'd1);
        check({tag, " Vsync"},      32'(Vsync),      32'd1);
        check({tag, " wr_ready"},   32'(wr_ready),   32'd0);
        check({tag, " wr_err"},     32'(wr_err),     32'd0);
        check({tag, " clear_busy"}, 32'(clear_busy), 32'd1);
    endtask

    // Arms the pending clear: v=515 without pix_en must not start it, the pix_en tick must.
    task automatic trigger_sweep(input logic hs);
        @(negedge clk);
        v_counter = 10'd515; h_counter = 10'd0; hsync_in = hs; vsync_in = 1'b1;
        repeat (3) @(negedge clk);
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{225, 36,  1'b1, 1'b1, GREEN};
        vecs[1]  = '{239, 50,  1'b1, 1'b1, GREEN};
        vecs[2]  = '{240, 36,  1'b1, 1'b1, BLACK};
        vecs[3]  = '{223, 36,  1'b1, 1'b1, BLACK};
        vecs[4]  = '{224, 35,  1'b0, 1'b1, GREEN};
        vecs[5]  = '{703, 514, 1'b0, 1'b1, RED};
        vecs[6]  = '{704, 514, 1'b1, 1'b0, BLACK};
        vecs[7]  = '{703, 515, 1'b1, 1'b0, BLACK};
        vecs[8]  = '{702, 34,  1'b1, 1'b1, BLACK};
        vecs[9]  = '{307, 156, 1'b1, 1'b1, BLUE};
        vecs[10] = '{272, 195, 1'b0, 1'b0, RED};
        vecs[11] = '{271, 195, 1'b1, 1'b1, BLACK};
        vecs[12] = '{0,   0,   1'b1, 1'b1, BLACK};

        rst = 1'b0; pix_en = 1'b0; h_counter = '0; v_counter = '0;
        hsync_in = 1'b1; vsync_in = 1'b1; wr_valid = 1'b0; wr_x = '0; wr_y = '0;
        wr_cell = '0; clear_req = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        rst = 1'b0;
        wait_idle(n_clk);
        check("power-on sweep length", 32'(n_clk), 32'd900);
        check("wr_ready after sweep", 32'(wr_ready), 32'd1);
        model_clear();
        flush();
        scan();

        write_cell(0, 0, 3, 1'b0);
        write_cell(29, 29, 2, 1'b0);
        write_cell(5, 7, 1, 1'b0);
        write_cell(3, 10, 2, 1'b0);
        flush();
        for (int i = 0; i < 13; i++)
            tick(vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].vs, vecs[i].rgb, 1'b1);
        flush();
        scan();

        write_cell(30, 3, 1, 1'b1);
        write_cell(3, 30, 2, 1'b1);
        scan();

        // Mid-frame clear at v=200, issued together with an out-of-range write.
        tick(273, 200, 1'b1, 1'b1, RED, 1'b1);
        flush();
        check("rgb before clear", 32'(rgb), 32'(RED));
        @(negedge clk);
        check("wr_ready before clear", 32'(wr_ready), 32'd1);
        clear_req = 1'b1; wr_valid = 1'b1; wr_x = 5'd31; wr_y = 5'd0; wr_cell = 2'd1;
        @(negedge clk);
        clear_req = 1'b0; wr_valid = 1'b0;
        check("clear_busy after clear_req", 32'(clear_busy), 32'd1);
        check("wr_ready while busy", 32'(wr_ready), 32'd0);
        check("wr_err for write beside clear_req", 32'(wr_err), 32'd1);
        @(negedge clk);
        check("rgb forced black", 32'(rgb), 32'(BLACK));
        wr_valid = 1'b1; wr_x = 5'd1; wr_y = 5'd1; wr_cell = 2'd3;
        tick(273, 201, 1'b1, 1'b1, BLACK, 1'b1);
        tick(273, 210, 1'b1, 1'b1, BLACK, 1'b1);
        tick(225, 36,  1'b1, 1'b1, BLACK, 1'b1);
        tick(703, 514, 1'b1, 1'b1, BLACK, 1'b1);
        tick(0, 0, 1'b1, 1'b1, BLACK, 1'b0);
        check("busy held through v=514", 32'(clear_busy), 32'd1);
        trigger_sweep(1'b1);
        wait_idle(n_clk);
        check("clear sweep length", 32'(n_clk), 32'd900);
        @(negedge clk);
        wr_valid = 1'b0;
        check("held write accepted cleanly", 32'(wr_err), 32'd0);
        model_clear();
        model[1][1] = 2'd3;
        flush();
        scan();

        // Reset in the middle of a sweep.
        write_cell(20, 25, 2, 1'b0);
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        tick(0, 520, 1'b0, 1'b1, BLACK, 1'b0);
        tick(0, 520, 1'b0, 1'b1, BLACK, 1'b1);
        tick(0, 520, 1'b0, 1'b1, BLACK, 1'b1);
        check("Hsync low before reset", 32'(Hsync), 32'd0);
        trigger_sweep(1'b0);
        repeat (399) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid-sweep reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hsync_in = 1'b1;
        wait_idle(n_clk);
        check("sweep length after reset", 32'(n_clk), 32'd900);
        model_clear();
        flush();
        scan();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
